// File: rtl/vga_timing_pkg.sv
// Default 720x480p timing constants and RGB565 field types.
// Shared by the timing generator and board-level tops.
package vga_timing_pkg;

  localparam int CLK_MHZ  = 27;

  localparam int H_ACTIVE = 720;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 62;
  localparam int H_BACK   = 60;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT
                          + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 9;
  localparam int V_SYNC   = 6;
  localparam int V_BACK   = 30;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT
                          + V_SYNC + V_BACK;

  localparam int W_X = 10;
  localparam int W_Y = 10;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  function automatic logic in_range(
    input int v,
    input int lo,
    input int hi
  );
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_pix_tick_gen.sv
// Clock-enable divider: one-clk strobe every pix_div clks.
// With pix_div = 1 the strobe is held high continuously.
module vga_pix_tick_gen #(
  parameter int pix_div = 1
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int CW =
    (pix_div > 1) ? $clog2(pix_div) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((pix_div > 1) ? pix_div - 1 : 0);

  if (pix_div < 1) begin : g_bad_div
    $error("vga_pix_tick_gen: pix_div must be >= 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign pix_tick = (cnt_q == LAST);

endmodule

// File: rtl/vga_rgb565_timing.sv
// Video timing generator with registered RGB565 and sync outputs.
// Colour sampled for x/y reaches the pins one pixel later.
module vga_rgb565_timing
  import vga_timing_pkg::*;
#(
  parameter int clk_mhz  = CLK_MHZ,
  parameter int pix_div  = 1,
  parameter int h_active = H_ACTIVE,
  parameter int h_front  = H_FRONT,
  parameter int h_sync   = H_SYNC,
  parameter int h_back   = H_BACK,
  parameter int v_active = V_ACTIVE,
  parameter int v_front  = V_FRONT,
  parameter int v_sync   = V_SYNC,
  parameter int v_back   = V_BACK,
  parameter int w_x      = W_X,
  parameter int w_y      = W_Y
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R_W-1:0] red_in,
  input  logic [G_W-1:0] green_in,
  input  logic [B_W-1:0] blue_in,
  output logic [w_x-1:0] x,
  output logic [w_y-1:0] y,
  output logic           display_on,
  output logic           pix_tick,
  output logic           frame_start,
  output logic           hsync,
  output logic           vsync,
  output logic [R_W-1:0] red,
  output logic [G_W-1:0] green,
  output logic [B_W-1:0] blue
);

  localparam int h_total =
    h_active + h_front + h_sync + h_back;
  localparam int v_total =
    v_active + v_front + v_sync + v_back;

  localparam int HS_LO = h_active + h_front;
  localparam int HS_HI = HS_LO + h_sync;
  localparam int VS_LO = v_active + v_front;
  localparam int VS_HI = VS_LO + v_sync;

  localparam logic [w_x-1:0] H_LAST =
    w_x'(h_total - 1);
  localparam logic [w_y-1:0] V_LAST =
    w_y'(v_total - 1);

  if (pix_div < 1) begin : g_bad_div
    $error("vga_rgb565_timing: pix_div must be >= 1");
  end
  if (h_total > (1 << w_x)) begin : g_bad_h
    $error("vga_rgb565_timing: h_total exceeds w_x");
  end
  if (v_total > (1 << w_y)) begin : g_bad_v
    $error("vga_rgb565_timing: v_total exceeds w_y");
  end
  if (clk_mhz < 1) begin : g_bad_clk
    $error("vga_rgb565_timing: clk_mhz must be >= 1");
  end

  logic           tick;
  logic [w_x-1:0] h_cnt_q, h_cnt_d;
  logic [w_y-1:0] v_cnt_q, v_cnt_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  rgb565_t        rgb_q, rgb_d;
  logic           hs_d, vs_d;
  logic           active;

  vga_pix_tick_gen #(
    .pix_div (pix_div)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (tick)
  );

  always_comb begin
    active = in_range(int'(h_cnt_q), 0, h_active)
          && in_range(int'(v_cnt_q), 0, v_active);
    hs_d   = in_range(int'(h_cnt_q), HS_LO, HS_HI);
    vs_d   = in_range(int'(v_cnt_q), VS_LO, VS_HI);
  end

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) v_cnt_d = '0;
        else v_cnt_d = v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Stage 2 holds between ticks so pins only move on pixel boundaries.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (tick) begin
      hsync_d = ~hs_d;
      vsync_d = ~vs_d;
      rgb_d   = '0;
      if (active) rgb_d = {red_in, green_in, blue_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign display_on  = active;
  assign pix_tick    = tick;
  assign frame_start = rst && tick
                    && (h_cnt_q == '0)
                    && (v_cnt_q == '0);
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = rgb_q.r;
  assign green       = rgb_q.g;
  assign blue        = rgb_q.b;

endmodule

// File: tb/tb_vga_rgb565_timing.sv
// Directed bench: full-size line, reduced-size frames,
// divided pixel clock and mid-frame asynchronous reset.
module tb_vga_rgb565_timing;

  int n_checks = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;

  // A: default 720x480 timing, constant white
  logic [9:0] x_a, y_a;
  logic       de_a, tk_a, fs_a, hs_a, vs_a;
  logic [4:0] r_a, b_a;
  logic [5:0] g_a;

  // B: 29x17 reduced timing, pix_div = 1
  logic [4:0] x_b, y_b;
  logic       de_b, tk_b, fs_b, hs_b, vs_b;
  logic [4:0] r_b, b_b, ri_b, bi_b;
  logic [5:0] g_b, gi_b;

  // C: 29x17 reduced timing, pix_div = 3
  logic [4:0] x_c, y_c;
  logic       de_c, tk_c, fs_c, hs_c, vs_c;
  logic [4:0] r_c, b_c, ri_c, bi_c;
  logic [5:0] g_c, gi_c;

  assign ri_b = x_b;
  assign gi_b = {1'b0, y_b};
  assign bi_b = ~x_b;
  assign ri_c = x_c;
  assign gi_c = {1'b0, y_c};
  assign bi_c = ~x_c;

  vga_rgb565_timing u_a (
    .clk(clk), .rst(rst_a),
    .red_in(5'h1F), .green_in(6'h3F), .blue_in(5'h1F),
    .x(x_a), .y(y_a), .display_on(de_a),
    .pix_tick(tk_a), .frame_start(fs_a),
    .hsync(hs_a), .vsync(vs_a),
    .red(r_a), .green(g_a), .blue(b_a)
  );

  vga_rgb565_timing #(
    .pix_div(1),
    .h_active(20), .h_front(2), .h_sync(4), .h_back(3),
    .v_active(10), .v_front(2), .v_sync(2), .v_back(3),
    .w_x(5), .w_y(5)
  ) u_b (
    .clk(clk), .rst(rst_b),
    .red_in(ri_b), .green_in(gi_b), .blue_in(bi_b),
    .x(x_b), .y(y_b), .display_on(de_b),
    .pix_tick(tk_b), .frame_start(fs_b),
    .hsync(hs_b), .vsync(vs_b),
    .red(r_b), .green(g_b), .blue(b_b)
  );

  vga_rgb565_timing #(
    .pix_div(3),
    .h_active(20), .h_front(2), .h_sync(4), .h_back(3),
    .v_active(10), .v_front(2), .v_sync(2), .v_back(3),
    .w_x(5), .w_y(5)
  ) u_c (
    .clk(clk), .rst(rst_c),
    .red_in(ri_c), .green_in(gi_c), .blue_in(bi_c),
    .x(x_c), .y(y_c), .display_on(de_c),
    .pix_tick(tk_c), .frame_start(fs_c),
    .hsync(hs_c), .vsync(vs_c),
    .red(r_c), .green(g_c), .blue(b_c)
  );

  // expected pins for a sampled pixel index p of the 29x17 raster
  function automatic logic [15:0] exp_rgb(input int p);
    int px, py;
    logic [4:0] xx, yy;
    px = p % 29;
    py = (p / 29) % 17;
    xx = px[4:0];
    yy = py[4:0];
    if (px < 20 && py < 10)
      return {xx, 1'b0, yy, ~xx};
    return 16'h0000;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({x_a, y_a} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_xy got %0d,%0d want 0,0", x_a, y_a);
    end
    n_checks++;
    if ({de_a, tk_a, fs_a} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 110",
               {de_a, tk_a, fs_a});
    end
    n_checks++;
    if ({hs_a, vs_a} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_sync got %b want 11", {hs_a, vs_a});
    end
    n_checks++;
    if ({r_a, g_a, b_a} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_rgb got %h want 0000",
               {r_a, g_a, b_a});
    end
    n_checks++;
    if ({tk_c, fs_c, de_c} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_div_flags got %b want 001",
               {tk_c, fs_c, de_c});
    end
  endtask

  task automatic test_line_default();
    int first_low = -1;
    int low_cnt   = 0;
    int de_cnt    = 0;
    int px;
    logic        hs_e;
    logic [15:0] rgb_e;
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    for (int n = 0; n <= 859; n++) begin
      px    = (n + 857) % 858;
      hs_e  = (n == 0) || !(px >= 736 && px < 798);
      rgb_e = (n >= 1 && px < 720) ? 16'hFFFF : 16'h0;
      if (hs_a === 1'b0) begin
        if (first_low < 0) first_low = n;
        low_cnt++;
      end
      if (n < 858 && de_a === 1'b1) de_cnt++;
      n_checks++;
      if (hs_a !== hs_e) begin
        n_fail++;
        $display("FAIL line_hsync n=%0d got %b want %b",
                 n, hs_a, hs_e);
      end
      n_checks++;
      if (de_a !== ((n % 858) < 720)) begin
        n_fail++;
        $display("FAIL line_de n=%0d got %b", n, de_a);
      end
      n_checks++;
      if ({r_a, g_a, b_a} !== rgb_e) begin
        n_fail++;
        $display("FAIL line_rgb n=%0d got %h want %h",
                 n, {r_a, g_a, b_a}, rgb_e);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (first_low != 737) begin
      n_fail++;
      $display("FAIL hsync_start got %0d want 737", first_low);
    end
    n_checks++;
    if (low_cnt != 62) begin
      n_fail++;
      $display("FAIL hsync_width got %0d want 62", low_cnt);
    end
    n_checks++;
    if (de_cnt != 720) begin
      n_fail++;
      $display("FAIL de_width got %0d want 720", de_cnt);
    end
  endtask

  task automatic test_frame_small();
    int fs_cnt = 0;
    int px, py;
    logic        hs_e, vs_e, de_e;
    logic [15:0] rgb_e;
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    for (int n = 0; n <= 986; n++) begin
      px    = (n + 492) % 29;
      py    = ((n + 492) / 29) % 17;
      hs_e  = (n == 0) || !(px >= 22 && px < 26);
      vs_e  = (n == 0) || !(py >= 12 && py < 14);
      rgb_e = (n == 0) ? 16'h0 : exp_rgb(n - 1);
      de_e  = ((n % 29) < 20) && (((n / 29) % 17) < 10);
      if (fs_b === 1'b1) fs_cnt++;
      n_checks++;
      if (x_b !== 5'(n % 29) || y_b !== 5'((n / 29) % 17)) begin
        n_fail++;
        $display("FAIL frame_xy n=%0d got %0d,%0d", n, x_b, y_b);
      end
      n_checks++;
      if (fs_b !== (n % 493 == 0)) begin
        n_fail++;
        $display("FAIL frame_start n=%0d got %b", n, fs_b);
      end
      n_checks++;
      if (de_b !== de_e) begin
        n_fail++;
        $display("FAIL frame_de n=%0d got %b want %b",
                 n, de_b, de_e);
      end
      n_checks++;
      if ({hs_b, vs_b} !== {hs_e, vs_e}) begin
        n_fail++;
        $display("FAIL frame_sync n=%0d got %b want %b",
                 n, {hs_b, vs_b}, {hs_e, vs_e});
      end
      n_checks++;
      if ({r_b, g_b, b_b} !== rgb_e) begin
        n_fail++;
        $display("FAIL frame_rgb n=%0d got %h want %h",
                 n, {r_b, g_b, b_b}, rgb_e);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (fs_cnt != 3) begin
      n_fail++;
      $display("FAIL frame_start_count got %0d want 3", fs_cnt);
    end
  endtask

  task automatic test_pix_div();
    int first_fs  = -1;
    int second_fs = -1;
    int p;
    logic [15:0] rgb_e;
    @(negedge clk);
    rst_c = 1'b1;
    #1;
    for (int n = 0; n <= 1482; n++) begin
      p     = n / 3;
      rgb_e = (p == 0) ? 16'h0 : exp_rgb(p - 1);
      if (fs_c === 1'b1) begin
        if (first_fs < 0) first_fs = n;
        else if (second_fs < 0) second_fs = n;
      end
      n_checks++;
      if (tk_c !== (n % 3 == 2)) begin
        n_fail++;
        $display("FAIL div_tick n=%0d got %b", n, tk_c);
      end
      n_checks++;
      if (x_c !== 5'(p % 29) || y_c !== 5'((p / 29) % 17)) begin
        n_fail++;
        $display("FAIL div_xy n=%0d got %0d,%0d", n, x_c, y_c);
      end
      n_checks++;
      if (fs_c !== (n % 3 == 2 && p % 493 == 0)) begin
        n_fail++;
        $display("FAIL div_frame_start n=%0d got %b", n, fs_c);
      end
      n_checks++;
      if ({r_c, g_c, b_c} !== rgb_e) begin
        n_fail++;
        $display("FAIL div_rgb n=%0d got %h want %h",
                 n, {r_c, g_c, b_c}, rgb_e);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (first_fs != 2 || second_fs != 1481) begin
      n_fail++;
      $display("FAIL div_frame_len got %0d,%0d want 2,1481",
               first_fs, second_fs);
    end
  endtask

  task automatic test_reset_mid_frame();
    int waited = 0;
    while (!(x_b == 5'd24 && y_b == 5'd12) && waited < 600) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_checks++;
    if (waited >= 600) begin
      n_fail++;
      $display("FAIL midrst_wait got timeout want x=24 y=12");
    end
    n_checks++;
    if ({hs_b, vs_b} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_pre_sync got %b want 00", {hs_b, vs_b});
    end
    #2;
    rst_b = 1'b0;
    #1;
    n_checks++;
    if ({x_b, y_b} !== 10'd0 || {hs_b, vs_b} !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_async got x=%0d y=%0d sync=%b want 0,0,11",
               x_b, y_b, {hs_b, vs_b});
    end
    n_checks++;
    if ({r_b, g_b, b_b} !== 16'h0 || {de_b, fs_b} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_outs got rgb=%h de_fs=%b want 0000,10",
               {r_b, g_b, b_b}, {de_b, fs_b});
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({x_b, y_b} !== 10'd0) begin
      n_fail++;
      $display("FAIL midrst_hold got %0d,%0d want 0,0", x_b, y_b);
    end
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    n_checks++;
    if ({x_b, y_b, fs_b} !== 11'b1) begin
      n_fail++;
      $display("FAIL midrst_release got x=%0d y=%0d fs=%b want 0,0,1",
               x_b, y_b, fs_b);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (x_b !== 5'd1 || fs_b !== 1'b0 || hs_b !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_next got x=%0d fs=%b hs=%b want 1,0,1",
               x_b, fs_b, hs_b);
    end
  endtask

  initial begin
    test_reset();
    test_line_default();
    test_frame_small();
    test_reset_mid_frame();
    test_pix_div();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
